// File: rtl/qrng_interval_extractor_pkg.sv
// Shared definitions for the QRNG interval extractor: pair-timing FSM states,
// byte geometry and the packer bit-insert helper.
package qrng_interval_extractor_pkg;

  localparam int BYTE_W    = 8;
  localparam int BIT_IDX_W = 3;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_T1   = 2'd1,
    ST_T2   = 2'd2
  } pair_state_e;

  // Writes one bit at an arbitrary position; the packer fills LSB-first.
  function automatic logic [BYTE_W-1:0] insert_bit(
    input logic [BYTE_W-1:0]    vec,
    input logic [BIT_IDX_W-1:0] idx,
    input logic                 b
  );
    logic [BYTE_W-1:0] res;
    res      = vec;
    res[idx] = b;
    return res;
  endfunction

endpackage

// File: rtl/qrng_interval_extractor_if.sv
// Byte output port of the interval extractor: valid/ready byte handshake plus
// the drop and discarded-pair status pulses.
interface qrng_interval_extractor_if;

  logic [qrng_interval_extractor_pkg::BYTE_W-1:0] byte_data;
  logic                                           byte_valid;
  logic                                           byte_ready;
  logic                                           byte_drop;
  logic                                           pair_disc;

  modport master (
    output byte_data,
    output byte_valid,
    output byte_drop,
    output pair_disc,
    input  byte_ready
  );

  modport slave (
    input  byte_data,
    input  byte_valid,
    input  byte_drop,
    input  pair_disc,
    output byte_ready
  );

endinterface

// File: rtl/qrng_interval_extractor_qualifier.sv
// Detector pulse qualifier: synchronises RXD, requires MIN_HIGH consecutive
// synced-high cycles and emits a single-cycle event per qualified pulse.
module qrng_interval_extractor_qualifier #(
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_rxd,
  output logic o_ev
);

  localparam int              RUN_W   = $clog2(MIN_HIGH + 1);
  localparam logic [RUN_W-1:0] RUN_SAT = RUN_W'(MIN_HIGH);
  localparam logic [RUN_W-1:0] RUN_ARM = RUN_W'(MIN_HIGH - 1);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [RUN_W-1:0]       r_run;
  logic                   r_ev;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_rxd};
    end
  end

  // Run length parks at MIN_HIGH so the arm value is crossed once per pulse;
  // any synced low re-arms the filter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_run <= '0;
    end else if (!w_synced) begin
      r_run <= '0;
    end else if (r_run != RUN_SAT) begin
      r_run <= r_run + RUN_ONE;
    end else begin
      r_run <= r_run;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ev <= 1'b0;
    end else begin
      r_ev <= w_synced && (r_run == RUN_ARM);
    end
  end

  assign o_ev = r_ev;

endmodule

// File: rtl/qrng_interval_extractor.sv
// QRNG entropy front end: times qualified detector events, turns each pair of
// intervals into one raw bit, packs bits LSB-first and offers bytes on a valid/ready port.
module qrng_interval_extractor
  import qrng_interval_extractor_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int MIN_HIGH    = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_rxd,
  qrng_interval_extractor_if.master  byte_if
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic                 w_ev;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     r_t1;
  pair_state_e          r_state;
  pair_state_e          w_state_nxt;
  logic                 w_pair_bad;
  logic                 w_t1_load;
  logic                 w_bit_vld;
  logic                 w_bit;
  logic                 w_disc;

  logic [BYTE_W-1:0]    r_shift;
  logic [BIT_IDX_W-1:0] r_bit_cnt;
  logic [BYTE_W-1:0]    w_shift_nxt;
  logic                 w_byte_done;

  logic [BYTE_W-1:0]    r_byte_data;
  logic                 r_byte_valid;
  logic                 r_byte_drop;
  logic                 r_pair_disc;
  logic                 w_accept;
  logic                 w_load;
  logic                 w_drop;
  logic                 w_valid_nxt;

  qrng_interval_extractor_qualifier #(
    .SYNC_STAGES (SYNC_STAGES),
    .MIN_HIGH    (MIN_HIGH)
  ) u_qual (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_rxd   (i_rxd),
    .o_ev    (w_ev)
  );

  // The event cycle itself counts as the first cycle of the next interval.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (w_ev) begin
      r_cnt <= CNT_ONE;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_t1    <= '0;
      r_state <= ST_IDLE;
    end else begin
      r_t1    <= w_t1_load ? r_cnt : r_t1;
      r_state <= w_state_nxt;
    end
  end

  // A saturated interval carries no ordering information, so it is discarded like a tie.
  assign w_pair_bad = (r_t1 == CNT_MAX) || (r_cnt == CNT_MAX) || (r_t1 == r_cnt);

  always_comb begin
    w_state_nxt = r_state;
    w_t1_load   = 1'b0;
    w_bit_vld   = 1'b0;
    w_bit       = 1'b0;
    w_disc      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ev) begin
          w_state_nxt = ST_T1;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_T1: begin
        if (w_ev) begin
          w_t1_load   = 1'b1;
          w_state_nxt = ST_T2;
        end else begin
          w_state_nxt = ST_T1;
        end
      end
      ST_T2: begin
        if (w_ev) begin
          w_state_nxt = ST_T1;
          if (w_pair_bad) begin
            w_disc = 1'b1;
          end else begin
            w_bit_vld = 1'b1;
            w_bit     = (r_t1 > r_cnt);
          end
        end else begin
          w_state_nxt = ST_T2;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_shift_nxt = insert_bit(r_shift, r_bit_cnt, w_bit);
  assign w_byte_done = w_bit_vld && (r_bit_cnt == 3'd7);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (w_bit_vld) begin
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= r_bit_cnt + 3'd1;
    end else begin
      r_shift   <= r_shift;
      r_bit_cnt <= r_bit_cnt;
    end
  end

  assign w_accept = r_byte_valid && byte_if.byte_ready;

  // A completed byte may replace the held one only when that one leaves this same cycle.
  always_comb begin
    w_load      = 1'b0;
    w_drop      = 1'b0;
    w_valid_nxt = r_byte_valid;
    if (w_byte_done) begin
      if (!r_byte_valid || w_accept) begin
        w_load      = 1'b1;
        w_valid_nxt = 1'b1;
      end else begin
        w_drop      = 1'b1;
        w_valid_nxt = r_byte_valid;
      end
    end else if (w_accept) begin
      w_valid_nxt = 1'b0;
    end else begin
      w_valid_nxt = r_byte_valid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_data  <= '0;
      r_byte_valid <= 1'b0;
      r_byte_drop  <= 1'b0;
      r_pair_disc  <= 1'b0;
    end else begin
      r_byte_data  <= w_load ? w_shift_nxt : r_byte_data;
      r_byte_valid <= w_valid_nxt;
      r_byte_drop  <= w_drop;
      r_pair_disc  <= w_disc;
    end
  end

  assign byte_if.byte_data  = r_byte_data;
  assign byte_if.byte_valid = r_byte_valid;
  assign byte_if.byte_drop  = r_byte_drop;
  assign byte_if.pair_disc  = r_pair_disc;

endmodule
